// File: rtl/wb_addr_decoder_if.sv
// Master-side Wishbone bus between the CPU and the address decoder.
// The decoder connects through the slave modport; the CPU or bench uses the master modport.
interface wb_addr_decoder_if #(
    parameter int AW = 20,
    parameter int DW = 16
);
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
    logic          we;
    logic          sel_byte;
    logic          stb;
    logic          ack;
    logic          err;

    modport master (
        output adr, wdat, we, sel_byte, stb,
        input  rdat, ack, err
    );

    modport slave (
        input  adr, wdat, we, sel_byte, stb,
        output rdat, ack, err
    );
endinterface

// File: rtl/wb_addr_decoder.sv
// Table-driven Wishbone address decoder and response mux with a registered response stage,
// a per-access timeout watchdog and error responses for unmapped or hung accesses.
module wb_addr_decoder #(
    parameter int                  NSLV    = 2,
    parameter int                  AW      = 20,
    parameter int                  DW      = 16,
    parameter logic [NSLV*AW-1:0]  BASE    = {20'h00000, 20'hB8000},
    parameter logic [NSLV*AW-1:0]  MASK    = {20'h00000, 20'hFE000},
    parameter int                  TO_CYC  = 255,
    parameter logic [DW-1:0]       ERR_DAT = 16'hFFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wb_addr_decoder_if.slave     m_if,
    output logic [NSLV-1:0]      s_stb_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic                 s_we_o,
    output logic                 s_byte_o,
    input  logic [NSLV*DW-1:0]   s_dat_i,
    input  logic [NSLV-1:0]      s_ack_i,
    output logic                 to_pulse_o,
    output logic [AW-1:0]        err_adr_o
);
    localparam int CW = $clog2(TO_CYC + 1);
    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   sel_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   dat_q;
    logic            ack_q;
    logic            err_q;
    logic            to_q;
    logic [AW-1:0]   err_adr_q;

    logic            hit_s;
    logic [SW-1:0]   hit_idx_s;
    logic            sel_ack_s;
    logic [DW-1:0]   sel_dat_s;

    // Region decode: scanning downwards lets the lowest matching index win.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if ((m_if.adr & MASK[k*AW +: AW]) == BASE[k*AW +: AW]) begin
                hit_s     = 1'b1;
                hit_idx_s = SW'(k);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    assign sel_ack_s = s_ack_i[sel_q];
    assign sel_dat_s = s_dat_i[int'(sel_q)*DW +: DW];

    // Only the latched slave sees the master strobe, and only while the access is in flight.
    always_comb begin
        s_stb_o = '0;
        if (state_q == ACTIVE) begin
            s_stb_o[sel_q] = m_if.stb;
        end else begin
            s_stb_o = '0;
        end
    end

    // Access FSM with registered response, timeout and error-capture outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            err_adr_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_if.stb && hit_s) begin
                        sel_q   <= hit_idx_s;
                        cnt_q   <= '0;
                        state_q <= ACTIVE;
                    end else if (m_if.stb) begin
                        err_adr_q <= m_if.adr;
                        dat_q     <= ERR_DAT;
                        err_q     <= 1'b1;
                        state_q   <= ERR;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACTIVE: begin
                    // Abort outranks everything; a late ack outranks the timeout.
                    if (!m_if.stb) begin
                        state_q <= IDLE;
                    end else if (sel_ack_s) begin
                        dat_q   <= sel_dat_s;
                        ack_q   <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TO_CYC - 1)) begin
                        err_adr_q <= m_if.adr;
                        dat_q     <= ERR_DAT;
                        to_q      <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_if.rdat  = dat_q;
    assign m_if.ack   = ack_q;
    assign m_if.err   = err_q;
    assign to_pulse_o = to_q;
    assign err_adr_o  = err_adr_q;

    assign s_adr_o  = m_if.adr;
    assign s_dat_o  = m_if.wdat;
    assign s_we_o   = m_if.we;
    assign s_byte_o = m_if.sel_byte;
endmodule
